// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with programmable access latency
// Optional tohost mailbox register is enabled by defining DMEM_TOHOST_EN.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_FFF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_TOHOST_EN
  ,
  output logic [31:0] tohost,
  output logic        tohost_vld
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        r_state, w_next;
  logic [3:0]    r_cnt, w_cnt_next;
  logic          w_enter_resp;
  logic          r_we;
  logic [31:0]   r_addr, r_wdata;
  logic [3:0]    r_be;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_we;
  logic [31:0]   w_addr, w_wdata, w_off;
  logic [3:0]    w_be;
  logic [AW-1:0] w_idx;
  logic          w_in_range, w_err, w_mem_we;
  logic [31:0]   w_rdata;

  always_comb begin
    w_next       = r_state;
    w_cnt_next   = r_cnt;
    w_enter_resp = 1'b0;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            w_next       = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next     = S_WAIT;
            w_cnt_next = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next       = S_RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // With zero wait cycles the access happens on the accept edge, before the latch is loaded.
  always_comb begin
    w_we       = (r_state == S_IDLE) ? req_we    : r_we;
    w_addr     = (r_state == S_IDLE) ? req_addr  : r_addr;
    w_wdata    = (r_state == S_IDLE) ? req_wdata : r_wdata;
    w_be       = (r_state == S_IDLE) ? req_be    : r_be;
    w_off      = w_addr - BASE_ADDR;
    w_idx      = AW'(w_off >> 2);
    w_in_range = (w_addr[1:0] == 2'b00) && (w_addr >= BASE_ADDR) && ({1'b0, w_addr} < END_ADDR);
  end

`ifdef DMEM_TOHOST_EN
  logic [31:0] r_tohost;
  logic        r_tohost_vld;
  logic        w_th_hit;

  always_comb begin
    w_th_hit = (w_addr == TOHOST_ADDR);
    w_err    = w_th_hit ? (w_we && (w_be != 4'hF)) : !w_in_range;
    w_mem_we = w_enter_resp && w_we && !w_err && !w_th_hit && !rst;
    w_rdata  = 32'h0;
    if (!w_we && !w_err) w_rdata = w_th_hit ? r_tohost : r_mem[w_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tohost     <= 32'h0;
      r_tohost_vld <= 1'b0;
    end else if (w_enter_resp && w_we && w_th_hit && !w_err) begin
      r_tohost     <= w_wdata;
      r_tohost_vld <= 1'b1;
    end
  end

  assign tohost     = r_tohost;
  assign tohost_vld = r_tohost_vld;
`else
  always_comb begin
    w_err    = !w_in_range;
    w_mem_we = w_enter_resp && w_we && !w_err && !rst;
    w_rdata  = 32'h0;
    if (!w_we && !w_err) w_rdata = r_mem[w_idx];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_be    <= 4'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (r_state == S_IDLE && req_valid) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
      end
      if (w_enter_resp) begin
        r_rdata <= w_rdata;
        r_err   <= w_err;
      end
    end
  end

  // Storage is deliberately left out of reset so contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
// Exercises the DMEM_TOHOST_EN mailbox when that macro is defined.
module tb_dmem_responder;

  localparam int DEPTH = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;
  logic        req_valid0, req_we0, req_ready0, rsp_valid0, rsp_ready0, rsp_err0;
  logic [31:0] req_addr0, req_wdata0, rsp_rdata0;
  logic [3:0]  req_be0;
`ifdef DMEM_TOHOST_EN
  logic [31:0] tohost, tohost0;
  logic        tohost_vld, tohost_vld0;
`endif

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DMEM_TOHOST_EN
    , .tohost(tohost), .tohost_vld(tohost_vld)
`endif
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0), .rsp_valid(rsp_valid0),
    .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
`ifdef DMEM_TOHOST_EN
    , .tohost(tohost0), .tohost_vld(tohost_vld0)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference model: byte-lane memory with a per-word "known" flag for never-written words.
  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  logic [31:0] m_tohost = 32'h0;

  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rd, output logic err,
                       output bit known);
    int idx;
    rd    = 32'h0;
    known = 1'b1;
`ifdef DMEM_TOHOST_EN
    if (addr == 32'h0000_FFF0) begin
      err = we && (be != 4'hF);
      if (we && !err) m_tohost = wdata;
      if (!we) rd = m_tohost;
      return;
    end
`endif
    err = (addr % 4 != 0) || (addr >= 4 * DEPTH);
    if (err) return;
    idx = int'(addr / 4);
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) m_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      if (be == 4'hF) m_known[idx] = 1'b1;
    end else begin
      rd    = m_mem[idx];
      known = m_known[idx];
    end
  endtask

  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int hold);
    logic [31:0] erd, rd0;
    logic        eerr;
    bit          eknown;
    int          n;
    model(we, addr, wdata, be, erd, eerr, eknown);
    @(negedge clk);
    check("idle_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(negedge clk);
    // Garbage requests while busy must be ignored.
    req_we = 1'($urandom); req_addr = $urandom & 32'h3C; req_wdata = $urandom; req_be = 4'hF;
    check("busy_req_ready", 32'(req_ready), 32'd0);
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      check("rsp_timeout", 32'(rsp_valid), 32'd1);
      req_valid = 1'b0;
      return;
    end
    check("latency", 32'(n), 32'd3);
    check("rsp_err", 32'(rsp_err), 32'(eerr));
    if (eknown) check("rsp_rdata", rsp_rdata, erd);
    rd0 = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, rd0);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_hs_valid", 32'(rsp_valid), 32'd0);
    check("post_hs_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] w0, a;
    rst = 1'b1;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0; rsp_ready = 0;
    req_valid0 = 0; req_we0 = 0; req_addr0 = 0; req_wdata0 = 0; req_be0 = 0; rsp_ready0 = 0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
`ifdef DMEM_TOHOST_EN
    check("rst_tohost", tohost, 32'h0);
    check("rst_tohost_vld", 32'(tohost_vld), 32'd0);
`endif
    rst = 1'b0;

    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
    check("load_10", rsp_rdata, 32'hDEADBEEF);
    txn(1'b1, 32'h20, 32'h11223344, 4'hF, 0);
    txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0);
    txn(1'b0, 32'h20, 32'h0, 4'hF, 0);
    check("load_20_merge", rsp_rdata, 32'h11BB33DD);
    txn(1'b0, 32'h22, 32'h0, 4'h0, 0);
    txn(1'b0, 32'(4 * DEPTH), 32'h0, 4'h0, 0);
    txn(1'b1, 32'h24, 32'hFFFFFFFF, 4'h0, 0);
    txn(1'b0, 32'h20, 32'h0, 4'h0, 5);
    txn(1'b1, 32'(4 * DEPTH - 4), 32'hCAFEF00D, 4'hF, 1);
    txn(1'b0, 32'(4 * DEPTH - 4), 32'h0, 4'h0, 0);

    // Reset during WAIT aborts the store.
    txn(1'b1, 32'h30, 32'h12345678, 4'hF, 0);
    txn(1'b0, 32'h30, 32'h0, 4'h0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h55; req_be = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("wait_rst_req_ready", 32'(req_ready), 32'd1);
    check("wait_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("wait_rst_rsp_rdata", rsp_rdata, 32'h0);
    check("wait_rst_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    txn(1'b0, 32'h30, 32'h0, 4'h0, 0);

`ifdef DMEM_TOHOST_EN
    txn(1'b1, 32'h0000_FFF0, 32'h1, 4'hF, 0);
    check("tohost", tohost, 32'h1);
    check("tohost_vld", 32'(tohost_vld), 32'd1);
    txn(1'b0, 32'h0000_FFF0, 32'h0, 4'h0, 0);
`endif

    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 5))
        0:       a = 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(1, 3));
        1:       a = 32'(4 * DEPTH) + 32'($urandom_range(0, 3) * 4);
        2:       a = 32'h0000_FFF0;
        3:       a = 32'hFFFF_FFFC;
        default: a = 32'($urandom_range(0, 15) * 4);
      endcase
      txn(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3));
    end

    // Zero-wait instance: request held high gives an accept every other cycle.
    w0 = $urandom;
    @(negedge clk);
    req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 32'h8; req_wdata0 = w0; req_be0 = 4'hF;
    rsp_ready0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("b2b_req_ready", 32'(req_ready0), 32'(i % 2 == 0));
      check("b2b_rsp_valid", 32'(rsp_valid0), 32'(i % 2 == 1));
      if (i % 2 == 1) begin
        check("b2b_rsp_err", 32'(rsp_err0), 32'd0);
        check("b2b_rdata", rsp_rdata0, (i == 1) ? 32'h0 : w0);
      end
      if (i == 1) req_we0 = 1'b0;
      @(negedge clk);
    end
    req_valid0 = 1'b0;
    rsp_ready0 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
